// File: rtl/i2s_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_deserializer
// Brief    : I2S (Philips) receiver. Rebuilds MSB-first slots into words and
//            presents them with a channel tag on a valid/ready interface.
//            Optional sign-extension check enabled by I2S_RX_SEXT_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx_deserializer #(
    parameter int WORD_W    = 32,
    parameter int PAYLOAD_W = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lr_clk,
    input  logic              sd,
    output logic [WORD_W-1:0] o_data,
    output logic              o_channel,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_overflow,
    output logic              o_len_err,
    output logic              o_sext_err
);

    localparam int                 c_CNT_W    = $clog2(WORD_W + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WORD_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(WORD_W + 1);
    localparam logic [0:0]         c_ST_SYNC  = 1'b0;
    localparam logic [0:0]         c_ST_RECV  = 1'b1;

    logic [0:0]         r_state;
    logic               r_ws;
    logic [WORD_W-1:0]  r_shift;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [WORD_W-1:0]  r_data;
    logic               r_channel;
    logic               r_valid;
    logic               r_overflow;
    logic               r_len_err;

    logic               w_boundary;
    logic               w_complete;
    logic               w_len_bad;
    logic [WORD_W-1:0]  w_word;

    assign w_boundary = (lr_clk != r_ws);
    assign w_complete = (r_state == c_ST_RECV) && w_boundary;
    // The boundary-edge bit belongs to the old slot, so a correct slot has
    // seen exactly WORD_W-1 bits before it.
    assign w_len_bad  = (r_bit_cnt != c_CNT_LAST);

    // Shift register with the current sd bit placed at its MSB-first slot;
    // bits beyond WORD_W match no position and are dropped.
    always_comb begin
        w_word = r_shift;
        for (int i = 0; i < WORD_W; i++) begin
            if (r_bit_cnt == c_CNT_W'(WORD_W - 1 - i)) begin
                w_word[i] = sd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_SYNC;
            r_ws       <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_channel  <= 1'b0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_ws <= lr_clk;

            if (w_boundary) begin
                r_state   <= c_ST_RECV;
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (r_state == c_ST_RECV) begin
                r_shift <= w_word;
                if (r_bit_cnt != c_CNT_SAT) begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                end
            end

            if (w_complete) begin
                if (!r_valid || i_ready) begin
                    r_data    <= w_word;
                    r_channel <= r_ws;
                    r_valid   <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
                if (w_len_bad) begin
                    r_len_err <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data     = r_data;
    assign o_channel  = r_channel;
    assign o_valid    = r_valid;
    assign o_overflow = r_overflow;
    assign o_len_err  = r_len_err;

`ifdef I2S_RX_SEXT_CHECK_EN
    logic [WORD_W-PAYLOAD_W:0] w_ext;
    logic                      w_sext_bad;
    logic                      r_sext_err;

    // Every bit from the payload MSB upward must be a copy of the sign.
    assign w_ext      = w_word[WORD_W-1:PAYLOAD_W-1];
    assign w_sext_bad = !((&w_ext) || !(|w_ext));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sext_err <= 1'b0;
        end else if (w_complete && w_sext_bad) begin
            r_sext_err <= 1'b1;
        end
    end

    assign o_sext_err = r_sext_err;
`else
    assign o_sext_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx_deserializer
// Brief    : Self-checking bench for i2s_rx_deserializer; slot-level stimulus
//            against a slot/word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_deserializer;

    localparam int W = 32;
    localparam int P = 22;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         lr_clk  = 1'b0;
    logic         sd      = 1'b0;
    logic         i_ready = 1'b0;
    logic [W-1:0] o_data;
    logic         o_channel;
    logic         o_valid;
    logic         o_overflow;
    logic         o_len_err;
    logic         o_sext_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    i2s_rx_deserializer #(.WORD_W(W), .PAYLOAD_W(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .lr_clk     (lr_clk),
        .sd         (sd),
        .o_data     (o_data),
        .o_channel  (o_channel),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_overflow (o_overflow),
        .o_len_err  (o_len_err),
        .o_sext_err (o_sext_err)
    );

    always #5 clk = ~clk;

    // Slot list: channel, length, bits left-aligned MSB-first in 64 bits
    logic        sl_ch[$];
    int          sl_len[$];
    logic [63:0] sl_bits[$];
    logic        cur_ch = 1'b0;

    // Per-bit stream derived from the slot list
    logic         q_lr[$];
    logic         q_sd[$];
    logic         q_end[$];
    logic         q_lenbad[$];
    logic [W-1:0] q_word[$];

    // Reference model of the output side
    logic         m_valid  = 1'b0;
    logic         m_ch     = 1'b0;
    logic [W-1:0] m_data   = '0;
    logic         m_ovf    = 1'b0;
    logic         m_len    = 1'b0;
    logic         m_sext   = 1'b0;
    logic         m_synced = 1'b0;

    function automatic logic [W+4:0] obs_vec();
        return {o_valid, (o_valid ? {o_channel, o_data} : {(W+1){1'b0}}),
                o_overflow, o_len_err, o_sext_err};
    endfunction

    function automatic logic [W+4:0] exp_vec();
        return {m_valid, (m_valid ? {m_ch, m_data} : {(W+1){1'b0}}),
                m_ovf, m_len, m_sext};
    endfunction

    function automatic logic [W-1:0] rand_sext();
        logic [31:0] r;
        r = $urandom;
        return {{(W-P){r[P-1]}}, r[P-1:0]};
    endfunction

`ifdef I2S_RX_SEXT_CHECK_EN
    function automatic logic sext_bad(input logic [W-1:0] w);
        logic [W-P:0] top;
        top = w[W-1:P-1];
        return !((top == '0) || (top == '1));
    endfunction
`endif

    task automatic add_slot(input int len, input logic [63:0] val);
        sl_ch.push_back(cur_ch);
        sl_len.push_back(len);
        sl_bits.push_back(val << (64 - len));
        cur_ch = ~cur_ch;
    endtask

    // I2S: the last bit of a slot is sent with the next slot's word select
    task automatic build_bits();
        int          len;
        logic        ch;
        logic [63:0] b;
        logic [W-1:0] w;
        while (sl_len.size() > 0) begin
            len = sl_len.pop_front();
            ch  = sl_ch.pop_front();
            b   = sl_bits.pop_front();
            w   = '0;
            for (int j = 0; j < len; j++) begin
                if (j < W) w[W-1-j] = b[63-j];
                q_sd.push_back(b[63-j]);
                q_lr.push_back((j == len - 1) ? ~ch : ch);
                q_end.push_back(j == len - 1);
                q_lenbad.push_back(len != W);
                q_word.push_back(w);
            end
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_ch = 1'b0; m_data = '0;
        m_ovf = 1'b0; m_len = 1'b0; m_sext = 1'b0; m_synced = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; lr_clk = 1'b0; sd = 1'($urandom); i_ready = 1'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc += 2;
        rst = 1'b0;
        model_reset();
        cur_ch = 1'b0;
    endtask

    // One bit time; the word channel is the slot's own select (before its last bit)
    task automatic drive_bit(input logic do_rst, input logic rdy);
        logic         e, lb;
        logic [W-1:0] w;
        logic         ch;
        lr_clk = q_lr.pop_front();
        sd     = q_sd.pop_front();
        e      = q_end.pop_front();
        lb     = q_lenbad.pop_front();
        w      = q_word.pop_front();
        ch     = e ? ~lr_clk : lr_clk;
        rst    = do_rst;
        i_ready = rdy;
        @(posedge clk);
        cyc++;
        if (do_rst) begin
            model_reset();
        end else if (e && !m_synced) begin
            m_synced = 1'b1;
        end else if (e) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1; m_data = w; m_ch = ch;
            end else begin
                m_ovf = 1'b1;
            end
            if (lb) m_len = 1'b1;
`ifdef I2S_RX_SEXT_CHECK_EN
            if (sext_bad(w)) m_sext = 1'b1;
`endif
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({o_valid, o_channel, o_data, o_overflow, o_len_err, o_sext_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b ch=%b d=%h f=%b%b%b required all zero",
                     o_valid, o_channel, o_data, o_overflow, o_len_err, o_sext_err);
        end
    endtask

    task automatic test_basic();
        logic seen_l = 1'b0, seen_r = 1'b0;
        add_slot(7, 64'($urandom));
        add_slot(W, 64'(rand_sext()));
        add_slot(W, 64'h0000_1234);
        add_slot(W, 64'hFFFF_FFFE);
        build_bits();
        for (int i = 0; q_lr.size() > 0; i++) begin
            drive_bit(1'b0, 1'b1);
            if (o_valid && !o_channel && o_data == 32'h0000_1234) seen_l = 1'b1;
            if (o_valid && o_channel && o_data == 32'hFFFF_FFFE) seen_r = 1'b1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic cyc=%0d got=%h required=%h {v,ch,data,ovf,len,sext}",
                         cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({seen_l, seen_r} !== 2'b11) begin
            errors++;
            $display("FAIL basic_words_seen got=%b required=11", {seen_l, seen_r});
        end
    endtask

    task automatic test_overflow();
        logic seen_drop = 1'b0;
        add_slot(W, 64'hA5A5_0001);
        add_slot(W, 64'h0000_0002);
        add_slot(W, 64'(rand_sext()));
        add_slot(W, 64'(rand_sext()));
        build_bits();
        for (int i = 0; q_lr.size() > 0; i++) begin
            drive_bit(1'b0, (i == 0) || (i >= 2 * W + 5));
            if (o_valid && o_channel && o_data == 32'h0000_0002) seen_drop = 1'b1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow cyc=%0d got=%h required=%h {v,ch,data,ovf,len,sext}",
                         cyc, obs_vec(), exp_vec());
            end
            if (i == 2 * W - 1) begin
                checks++;
                if ({o_valid, o_channel, o_data, o_overflow} !== {1'b1, 1'b0, 32'hA5A5_0001, 1'b1}) begin
                    errors++;
                    $display("FAIL overflow_hold got v=%b ch=%b d=%h ovf=%b required v=1 ch=0 d=a5a50001 ovf=1",
                             o_valid, o_channel, o_data, o_overflow);
                end
            end
        end
        checks++;
        if (seen_drop !== 1'b0) begin
            errors++;
            $display("FAIL overflow_dropped_word_seen got=%b required=0", seen_drop);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1, w2;
        w1 = rand_sext();
        w2 = rand_sext();
        apply_reset();
        add_slot(5, 64'($urandom));
        add_slot(W, 64'(w1));
        add_slot(W, 64'(w2));
        build_bits();
        for (int i = 0; q_lr.size() > 0; i++) begin
            drive_bit(1'b0, i == 5 + 2 * W - 1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%h required=%h {v,ch,data,ovf,len,sext}",
                         cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({o_valid, o_channel, o_data, o_overflow} !== {1'b1, 1'b0, w2, 1'b0}) begin
            errors++;
            $display("FAIL back_to_back_load got v=%b ch=%b d=%h ovf=%b required v=1 ch=0 d=%h ovf=0",
                     o_valid, o_channel, o_data, o_overflow, w2);
        end
    endtask

    task automatic test_length();
        logic seen_short = 1'b0, seen_long = 1'b0;
        add_slot(16, 64'hABCD);
        add_slot(40, 64'h12_3456_789A);
        add_slot(W, 64'(rand_sext()));
        build_bits();
        for (int i = 0; q_lr.size() > 0; i++) begin
            drive_bit(1'b0, 1'b1);
            if (o_valid && o_channel && o_data == 32'hABCD_0000) seen_short = 1'b1;
            if (o_valid && !o_channel && o_data == 32'h1234_5678) seen_long = 1'b1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL length cyc=%0d got=%h required=%h {v,ch,data,ovf,len,sext}",
                         cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({seen_short, seen_long, o_len_err} !== 3'b111) begin
            errors++;
            $display("FAIL length_words got short=%b long=%b len_err=%b required 1 1 1",
                     seen_short, seen_long, o_len_err);
        end
    endtask

    task automatic test_mid_reset();
        add_slot(W, {$urandom, $urandom});
        add_slot(W, 64'(rand_sext()));
        add_slot(W, 64'(rand_sext()));
        build_bits();
        for (int i = 0; q_lr.size() > 0; i++) begin
            drive_bit(i == 10, 1'($urandom));
            if (i == 10) begin
                cur_ch = 1'b1;
                checks++;
                if ({o_valid, o_channel, o_data, o_overflow, o_len_err, o_sext_err} !== '0) begin
                    errors++;
                    $display("FAIL mid_reset_outputs got v=%b ch=%b d=%h f=%b%b%b required all zero",
                             o_valid, o_channel, o_data, o_overflow, o_len_err, o_sext_err);
                end
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mid_reset cyc=%0d got=%h required=%h {v,ch,data,ovf,len,sext}",
                         cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 40; s++) begin
            add_slot(($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 44)) : W,
                     {$urandom, $urandom});
        end
        build_bits();
        for (int i = 0; q_lr.size() > 0; i++) begin
            drive_bit(1'b0, $urandom_range(0, 3) != 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h required=%h {v,ch,data,ovf,len,sext}",
                         cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_sext();
        logic exp_bad;
`ifdef I2S_RX_SEXT_CHECK_EN
        exp_bad = 1'b1;
`else
        exp_bad = 1'b0;
`endif
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            add_slot(4, 64'($urandom));
            add_slot(W, (pass == 0) ? 64'h0020_0000 : 64'hFFE0_0000);
            add_slot(W, 64'(rand_sext()));
            build_bits();
            for (int i = 0; q_lr.size() > 0; i++) begin
                drive_bit(1'b0, 1'b1);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL sext cyc=%0d got=%h required=%h {v,ch,data,ovf,len,sext}",
                             cyc, obs_vec(), exp_vec());
                end
            end
            checks++;
            if (o_sext_err !== ((pass == 0) ? exp_bad : 1'b0)) begin
                errors++;
                $display("FAIL sext_flag pass=%0d got=%b required=%b",
                         pass, o_sext_err, (pass == 0) ? exp_bad : 1'b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_length();
        test_mid_reset();
        test_random();
        test_sext();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
